rv_muldiv_unit: RTL and testbench
=================================

Name: rv_muldiv_unit

Overview:
- Parametrised iterative RV32M/RV64M multiply-divide execute unit; companion to the integer ALU in the execute stage of the RISC-V core.
- Accepts one M-extension operation per handshake and computes it over multiple cycles with radix-2 shift-add (multiply) and restoring (divide) datapaths.
- Returns the result with the destination tag over a valid/ready output, so the pipeline can stall or flush around it.

Parameters:
XLEN, 32, operand/result width in bits; legal values 16, 32, 64.
TAG_W, 5, width of the opaque tag (rd index) carried from input to output.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset.
flush  input  1  synchronous abort of any operation in flight.
in_valid  input  1  operation request valid.
in_ready  output  1  unit can accept; 1 only in IDLE.
in_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
in_rs1  input  XLEN  operand A (multiplicand/dividend).
in_rs2  input  XLEN  operand B (multiplier/divisor).
in_tag  input  TAG_W  tag returned with the result.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_result  output  XLEN  result.
out_tag  output  TAG_W  tag of the result.
busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; in_ready=1, out_valid=0, out_result=0, out_tag=0, busy=0; step counter and internal registers cleared. Any operation in progress is lost.
- States: IDLE, CALC, FIX, DONE.
- Accept occurs on the rising edge with in_valid & in_ready & !flush. That edge latches operands, funct3 and tag.
- Signed operands:
  - Signed ops (MULH, DIV, REM, and rs1 of MULHSU) latch the absolute values of the operands.
  - The result sign is recorded at accept.
- Special cases are decided at the accept edge and go straight to DONE, so out_valid=1 after the next edge:
  - DIV/DIVU divisor 0: quotient all ones.
  - REM/REMU divisor 0: result = rs1.
  - DIV with rs1 = most-negative and rs2 = -1: result = rs1 (most-negative).
  - REM with rs1 = most-negative and rs2 = -1: result = 0.
- Normal path:
  - IDLE->CALC on accept.
  - CALC performs one step per edge for exactly XLEN edges (counter 0..XLEN-1).
  - After the last step the unit moves to FIX. The FIX edge applies two's-complement negation where required and selects the result.
  - DIV quotient is negated if the operand signs differ. REM remainder takes the dividend's sign.
  - Result selection: MUL returns the low XLEN bits of the 2*XLEN product. MULH, MULHSU and MULHU return the high XLEN bits.
  - FIX->DONE. With the accept edge as edge 0, out_valid goes high after edge XLEN+1 (XLEN+1 cycles of latency).
- Product width: 2*XLEN internally; no truncation before selection.
- DONE:
  - out_valid=1; out_result and out_tag stay stable until out_ready=1.
  - On the edge with out_valid & out_ready, the unit goes to IDLE and out_valid drops.
  - There is no accept in that same edge: in_ready is 0 in DONE, giving a minimum of 1 idle cycle between operations.
- out_result and out_tag hold their last value when out_valid=0.
- flush = 1 has the highest priority over everything but reset:
  - From any state, the next edge goes to IDLE and out_valid=0.
  - A simultaneous in_valid is not accepted.
  - A simultaneous out_ready handshake in DONE is discarded, not counted as delivered.
- busy = (state != IDLE).
- Operand changes after accept have no effect on the operation in flight.

Test Plan:
- XLEN=32, MUL rs1=7 rs2=0xFFFFFFFD (-3) -> out_result 0xFFFFFFEB, out_valid exactly 33 cycles after accept, tag echoed.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU rs1=0xFFFFFFFF rs2=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100,7 -> 2.
- Special cases, each with out_valid 1 cycle after accept:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5,0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000,0xFFFFFFFF -> 0.
- Backpressure and tags:
  - Hold out_ready=0 for 10 cycles in DONE -> result and tag stable, in_ready=0.
  - Raise out_ready -> IDLE next cycle; the next in_valid is accepted with the correct new tag.
- Abort paths:
  - flush at CALC step 10 -> IDLE next cycle, no out_valid.
  - Async rst pulse mid-CALC (no clock edge) -> outputs reset immediately.
  - XLEN=16 regression: MUL 0x00FF x 0x0101 -> 0xFFFF, latency 17.

Source files
------------

// File: rtl/rv_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
// The master issues operations and consumes results; the slave is the unit itself.
interface rv_muldiv_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M execute unit: radix-2 shift-add multiply, restoring divide,
// one bit per cycle over XLEN cycles, sign fix-up in a final cycle.
module rv_muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    rv_muldiv_unit_if.slave bus,
    output logic            o_busy
);
    localparam int unsigned      CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LastStep = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MinNeg   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_funct3;
    logic [TAG_W-1:0]   r_tag;
    logic [XLEN-1:0]    r_opnd;
    logic [2*XLEN-1:0]  r_prod;
    logic               r_neg;
    logic               r_out_valid;
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_out_tag;

    logic               w_s1, w_s2, w_sgn_a, w_sgn_b, w_is_div;
    logic               w_div0, w_ovf, w_special, w_neg;
    logic [XLEN-1:0]    w_abs_a, w_abs_b;
    logic [2*XLEN-1:0]  w_init;
    logic [XLEN:0]      w_sum, w_trial, w_diff;
    logic [2*XLEN-1:0]  w_step, w_mul_fix;
    logic [XLEN-1:0]    w_div_sel, w_div_fix, w_result;

    // Accept-side operand conditioning and special-case detection.
    always_comb begin
        w_s1      = bus.in_rs1[XLEN-1];
        w_s2      = bus.in_rs2[XLEN-1];
        w_sgn_a   = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b010) ||
                    (bus.in_funct3 == 3'b100) || (bus.in_funct3 == 3'b110);
        w_sgn_b   = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b100) ||
                    (bus.in_funct3 == 3'b110);
        w_abs_a   = (w_sgn_a && w_s1) ? -bus.in_rs1 : bus.in_rs1;
        w_abs_b   = (w_sgn_b && w_s2) ? -bus.in_rs2 : bus.in_rs2;
        w_neg     = (bus.in_funct3 == 3'b110) ? w_s1 : ((w_sgn_a && w_s1) ^ (w_sgn_b && w_s2));
        w_is_div  = bus.in_funct3[2];
        w_div0    = w_is_div && (bus.in_rs2 == '0);
        w_ovf     = ((bus.in_funct3 == 3'b100) || (bus.in_funct3 == 3'b110)) &&
                    (bus.in_rs1 == MinNeg) && (bus.in_rs2 == '1);
        w_special = w_div0 || w_ovf;
        // Special cases preload {rem, quot} so the FIX cycle selects the architected answer.
        if (w_div0) begin
            w_init = bus.in_funct3[1] ? {bus.in_rs1, {XLEN{1'b0}}} : {{XLEN{1'b0}}, {XLEN{1'b1}}};
        end else if (w_ovf) begin
            w_init = bus.in_funct3[1] ? '0 : {{XLEN{1'b0}}, bus.in_rs1};
        end else begin
            w_init = w_is_div ? {{XLEN{1'b0}}, w_abs_a} : {{XLEN{1'b0}}, w_abs_b};
        end
    end

    // One iteration: multiply keeps {acc, multiplier} and shifts right; divide keeps
    // {rem, quot} and shifts left, subtracting the divisor when it fits.
    always_comb begin
        w_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                  (r_prod[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_trial = r_prod[2*XLEN-1:XLEN-1];
        w_diff  = w_trial - {1'b0, r_opnd};
        if (!r_funct3[2]) begin
            w_step = {w_sum, r_prod[XLEN-1:1]};
        end else if (w_diff[XLEN]) begin
            w_step = {w_trial[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
        end else begin
            w_step = {w_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        w_mul_fix = r_neg ? -r_prod : r_prod;
        w_div_sel = r_funct3[1] ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];
        w_div_fix = r_neg ? -w_div_sel : w_div_sel;
        if (r_funct3[2]) begin
            w_result = w_div_fix;
        end else if (r_funct3[1:0] == 2'b00) begin
            w_result = w_mul_fix[XLEN-1:0];
        end else begin
            w_result = w_mul_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_funct3    <= '0;
            r_tag       <= '0;
            r_opnd      <= '0;
            r_prod      <= '0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_out_tag   <= '0;
        end else if (i_flush) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_funct3 <= bus.in_funct3;
                        r_tag    <= bus.in_tag;
                        r_opnd   <= bus.in_funct3[2] ? w_abs_b : w_abs_a;
                        r_prod   <= w_init;
                        r_neg    <= w_neg && !w_special;
                        r_cnt    <= '0;
                        r_state  <= w_special ? StFix : StCalc;
                    end
                end
                StCalc: begin
                    r_prod <= w_step;
                    if (r_cnt == LastStep) begin
                        r_cnt   <= '0;
                        r_state <= StFix;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StFix: begin
                    r_result    <= w_result;
                    r_out_tag   <= r_tag;
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == StIdle);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_result;
    assign bus.out_tag    = r_out_tag;
    assign o_busy         = (r_state != StIdle);
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit: vector table plus scoreboard queue,
// with hand-written flush, reset, backpressure and XLEN=16 sequences.
module tb_rv_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush16 = 1'b0;
    logic busy32, busy16;

    always #5 clk = ~clk;

    rv_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) bus32 ();
    rv_muldiv_unit_if #(.XLEN(16), .TAG_W(5)) bus16 ();

    rv_muldiv_unit #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .i_clk(clk), .i_rst(rst_n), .i_flush(flush), .bus(bus32), .o_busy(busy32)
    );
    rv_muldiv_unit #(.XLEN(16), .TAG_W(5)) u_dut16 (
        .i_clk(clk), .i_rst(rst_n), .i_flush(flush16), .bus(bus16), .o_busy(busy16)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref32(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        p  = '0;
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int lat32(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
        if (f3[2] && (b == 0 || ((f3 == 3'd4 || f3 == 3'd6) &&
                                 a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    task automatic run32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic [4:0] tag, input int lat,
                         input int hold);
        sb_t e;
        int  n;
        @(negedge clk);
        chk("in_ready_idle", 64'(bus32.in_ready), 64'd1);
        bus32.in_valid  = 1'b1;
        bus32.in_funct3 = f3;
        bus32.in_rs1    = a;
        bus32.in_rs2    = b;
        bus32.in_tag    = tag;
        @(posedge clk);
        e.res = exp;
        e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        // Scramble the request lines so the op in flight must rely on latched copies.
        bus32.in_valid  = 1'b0;
        bus32.in_funct3 = 3'($urandom);
        bus32.in_rs1    = $urandom;
        bus32.in_rs2    = $urandom;
        bus32.in_tag    = 5'($urandom);
        n = 0;
        while (!bus32.out_valid && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", 64'(n), 64'(lat));
        if (sb_q.size() > 0) e = sb_q.pop_front();
        if (bus32.out_valid) begin
            chk("result", 64'(bus32.out_result), 64'(e.res));
            chk("tag", 64'(bus32.out_tag), 64'(e.tag));
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                chk("hold_valid", 64'(bus32.out_valid), 64'd1);
                chk("hold_result", 64'(bus32.out_result), 64'(e.res));
                chk("hold_tag", 64'(bus32.out_tag), 64'(e.tag));
                chk("hold_in_ready", 64'(bus32.in_ready), 64'd0);
            end
            bus32.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus32.out_ready = 1'b0;
            chk("valid_drop", 64'(bus32.out_valid), 64'd0);
            chk("ready_back", 64'(bus32.in_ready), 64'd1);
            chk("result_held", 64'(bus32.out_result), 64'(e.res));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          seen;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        bus32.in_valid = 1'b0; bus32.in_funct3 = '0; bus32.in_rs1 = '0;
        bus32.in_rs2 = '0; bus32.in_tag = '0; bus32.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_funct3 = '0; bus16.in_rs1 = '0;
        bus16.in_rs2 = '0; bus16.in_tag = '0; bus16.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("rst_result", 64'(bus32.out_result), 64'd0);
        chk("rst_tag", 64'(bus32.out_tag), 64'd0);
        chk("rst_busy", 64'(busy32), 64'd0);
        rst_n = 1'b1;

        vecs.push_back('{f3: 3'd0, a: 32'd7,          b: 32'hFFFF_FFFD, exp: 32'hFFFF_FFEB, lat: 33, hold: 0});
        vecs.push_back('{f3: 3'd3, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFE, lat: 33, hold: 0});
        vecs.push_back('{f3: 3'd1, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'h0000_0000, lat: 33, hold: 0});
        vecs.push_back('{f3: 3'd2, a: 32'hFFFF_FFFF, b: 32'd2,          exp: 32'hFFFF_FFFF, lat: 33, hold: 0});
        vecs.push_back('{f3: 3'd4, a: 32'hFFFF_FFF9, b: 32'd2,          exp: 32'hFFFF_FFFD, lat: 33, hold: 0});
        vecs.push_back('{f3: 3'd6, a: 32'hFFFF_FFF9, b: 32'd2,          exp: 32'hFFFF_FFFF, lat: 33, hold: 0});
        vecs.push_back('{f3: 3'd5, a: 32'd100,       b: 32'd7,          exp: 32'd14,        lat: 33, hold: 0});
        vecs.push_back('{f3: 3'd7, a: 32'd100,       b: 32'd7,          exp: 32'd2,         lat: 33, hold: 0});
        vecs.push_back('{f3: 3'd4, a: 32'd5,         b: 32'd0,          exp: 32'hFFFF_FFFF, lat: 1,  hold: 0});
        vecs.push_back('{f3: 3'd7, a: 32'd5,         b: 32'd0,          exp: 32'd5,         lat: 1,  hold: 0});
        vecs.push_back('{f3: 3'd4, a: 32'h8000_0000, b: 32'hFFFF_FFFF, exp: 32'h8000_0000, lat: 1,  hold: 0});
        vecs.push_back('{f3: 3'd6, a: 32'h8000_0000, b: 32'hFFFF_FFFF, exp: 32'd0,         lat: 1,  hold: 0});
        vecs.push_back('{f3: 3'd0, a: 32'h0001_2345, b: 32'h0000_0100, exp: 32'h0123_4500, lat: 33, hold: 10});
        vecs.push_back('{f3: 3'd5, a: 32'd1000,      b: 32'd10,         exp: 32'd100,       lat: 33, hold: 0});

        foreach (vecs[i])
            run32(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 5'(i + 3), vecs[i].lat,
                  vecs[i].hold);

        for (int i = 0; i < 8; i++) begin
            rf3 = 3'(i);
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : $urandom;
            run32(rf3, ra, rb, ref32(rf3, ra, rb), 5'($urandom), lat32(rf3, ra, rb), 0);
        end

        // Flush at CALC step 10: nothing must come out.
        @(negedge clk);
        bus32.in_valid = 1'b1; bus32.in_funct3 = 3'd0;
        bus32.in_rs1 = 32'd3; bus32.in_rs2 = 32'd4; bus32.in_tag = 5'd17;
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_flush_busy", 64'(busy32), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy32), 64'd0);
        chk("flush_in_ready", 64'(bus32.in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus32.out_valid || busy32) seen = 1;
        end
        chk("flush_no_output", 64'(seen), 64'd0);

        // Flush beats a simultaneous request.
        @(negedge clk);
        bus32.in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", 64'(busy32), 64'd0);

        // Asynchronous reset mid-CALC, away from any clock edge.
        run32(3'd0, 32'd6, 32'd7, 32'd42, 5'd21, 33, 0);
        @(negedge clk);
        bus32.in_valid = 1'b1; bus32.in_funct3 = 3'd0;
        bus32.in_rs1 = 32'd9; bus32.in_rs2 = 32'd9; bus32.in_tag = 5'd22;
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy32), 64'd0);
        chk("arst_in_ready", 64'(bus32.in_ready), 64'd1);
        chk("arst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("arst_result", 64'(bus32.out_result), 64'd0);
        chk("arst_tag", 64'(bus32.out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run32(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd30, 33, 0);

        // XLEN=16 instance.
        @(negedge clk);
        bus16.in_valid = 1'b1; bus16.in_funct3 = 3'd0;
        bus16.in_rs1 = 16'h00FF; bus16.in_rs2 = 16'h0101; bus16.in_tag = 5'd9;
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0; bus16.in_rs1 = 16'h1234; bus16.in_rs2 = 16'h5678;
        n = 0;
        while (!bus16.out_valid && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("x16_latency", 64'(n), 64'd17);
        chk("x16_result", 64'(bus16.out_result), 64'hFFFF);
        chk("x16_tag", 64'(bus16.out_tag), 64'd9);
        bus16.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.out_ready = 1'b0;
        chk("x16_valid_drop", 64'(bus16.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
